// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - programmable tick generator with periodic/one-shot modes
//
// Counts clk cycles from 0 up to a programmable terminal value P, then wraps
// to 0 and emits a one-cycle tick. The tick period is P+1 enabled cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         count enable; low freezes count and suppresses tick
//   mode       0 = periodic, 1 = one-shot (sampled at terminal count)
//   start      one-cycle strobe; begins or restarts a count from 0
//   period_in  new terminal count value
//   period_wr  one-cycle strobe; writes period_in into the shadow register
//   count      current counter value
//   tick       registered one-cycle pulse on the wrap from P to 0
//   toggle     inverts at every tick (divided clock)
//   busy       high while running
module tick_divider #(
    parameter int WIDTH          = 25,
    parameter int DEFAULT_PERIOD = 25000000,
    parameter bit AUTO_START     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic [WIDTH-1:0] period_in,
    input  logic             period_wr,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             toggle,
    output logic             busy
);

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] period_q,  period_d;
    logic [WIDTH-1:0] shadow_q,  shadow_d;
    logic             pending_q, pending_d;
    logic             tick_q,    tick_d;
    logic             toggle_q,  toggle_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= AUTO_START ? ST_RUN : ST_IDLE;
            count_q   <= '0;
            period_q  <= DEF_P;
            shadow_q  <= DEF_P;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            toggle_q  <= toggle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        toggle_d  = toggle_q;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                // Nothing is counting, so a new period can land in P at once.
                if (period_wr) begin
                    period_d  = period_in;
                    shadow_d  = period_in;
                    pending_d = 1'b0;
                end
                if (start) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (start) begin
                    // Restart beats a coincident terminal count: no tick, no
                    // toggle flip. The new count begins at 0, so a pending
                    // period can safely take over here.
                    count_d = '0;
                    if (pending_q) begin
                        period_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                    if (period_wr) begin
                        shadow_d  = period_in;
                        pending_d = 1'b1;
                    end
                end else if (en && (count_q == period_q)) begin
                    count_d  = '0;
                    tick_d   = 1'b1;
                    toggle_d = ~toggle_q;
                    // A write on the wrap cycle itself is newer than any
                    // shadow value, so it goes straight into P.
                    if (period_wr) begin
                        period_d  = period_in;
                        shadow_d  = period_in;
                        pending_d = 1'b0;
                    end else if (pending_q) begin
                        period_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                    if (mode) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (en) begin
                        count_d = count_q + WIDTH'(1);
                    end
                    // P stays fixed mid-count so count never exceeds it;
                    // the new value waits in the shadow until the next wrap.
                    if (period_wr) begin
                        shadow_d  = period_in;
                        pending_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign count  = count_q;
    assign tick   = tick_q;
    assign toggle = toggle_q;
    assign busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_tick_divider.sv
// tb/tb_tick_divider.sv - self-checking bench for tick_divider
module tb_tick_divider;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: auto-start, periodic tests
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       mode = 1'b0;
    logic       start = 1'b0;
    logic [3:0] period_in = 4'd0;
    logic       period_wr = 1'b0;
    logic [3:0] count;
    logic       tick, toggle, busy;

    // Instance B: waits for start, one-shot
    logic       rst_b = 1'b0;
    logic       en_b = 1'b1;
    logic       mode_b = 1'b1;
    logic       start_b = 1'b0;
    logic [3:0] period_in_b = 4'd0;
    logic       period_wr_b = 1'b0;
    logic [3:0] count_b;
    logic       tick_b, toggle_b, busy_b;

    tick_divider #(.WIDTH(4), .DEFAULT_PERIOD(4), .AUTO_START(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
        .period_in(period_in), .period_wr(period_wr),
        .count(count), .tick(tick), .toggle(toggle), .busy(busy)
    );

    tick_divider #(.WIDTH(4), .DEFAULT_PERIOD(4), .AUTO_START(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .start(start_b),
        .period_in(period_in_b), .period_wr(period_wr_b),
        .count(count_b), .tick(tick_b), .toggle(toggle_b), .busy(busy_b)
    );

    typedef struct {
        int         which;
        logic [3:0] c;
        logic       t;
        logic       tg;
        logic       b;
    } exp_t;

    exp_t  sb[$];
    int    n_assert = 0;
    int    n_fail = 0;
    string phase = "init";
    logic  tg;
    logic  tgb;
    logic  t;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    // Queue the expectation for the coming edge, then check after the edge.
    task automatic step(input int which, input logic [3:0] c, input logic et,
                        input logic etg, input logic eb);
        exp_t e;
        e.which = which; e.c = c; e.t = et; e.tg = etg; e.b = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.which == 0) begin
            chk("count",  count,           e.c);
            chk("tick",   {3'b0, tick},    {3'b0, e.t});
            chk("toggle", {3'b0, toggle},  {3'b0, e.tg});
            chk("busy",   {3'b0, busy},    {3'b0, e.b});
        end else begin
            chk("count_b",  count_b,          e.c);
            chk("tick_b",   {3'b0, tick_b},   {3'b0, e.t});
            chk("toggle_b", {3'b0, toggle_b}, {3'b0, e.tg});
            chk("busy_b",   {3'b0, busy_b},   {3'b0, e.b});
        end
    endtask

    task automatic reset_a();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        rst   = 1'b1;
        rst_b = 1'b1;
        #1;
        phase = "reset";
        chk("count",  count,            4'd0);
        chk("tick",   {3'b0, tick},     4'd0);
        chk("toggle", {3'b0, toggle},   4'd0);
        chk("busy",   {3'b0, busy},     4'd1);
        chk("busy_b", {3'b0, busy_b},   4'd0);
        chk("count_b", count_b,         4'd0);
        @(negedge clk);
        rst   = 1'b0;
        rst_b = 1'b0;

        phase = "periodic";
        tg = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            t = (i % 5 == 0);
            if (t) tg = ~tg;
            step(0, 4'(i % 5), t, tg, 1'b1);
        end

        phase = "shadow_wr";
        step(0, 4'd1, 1'b0, tg, 1'b1);
        step(0, 4'd2, 1'b0, tg, 1'b1);
        period_wr = 1'b1; period_in = 4'd2;
        step(0, 4'd3, 1'b0, tg, 1'b1);
        period_wr = 1'b0;
        step(0, 4'd4, 1'b0, tg, 1'b1);
        tg = ~tg;
        step(0, 4'd0, 1'b1, tg, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            t = (k % 3 == 0);
            if (t) tg = ~tg;
            step(0, 4'(k % 3), t, tg, 1'b1);
        end

        phase = "wr_at_wrap";
        reset_a();
        tg = 1'b0;
        for (int i = 1; i <= 4; i++) step(0, 4'(i), 1'b0, tg, 1'b1);
        period_wr = 1'b1; period_in = 4'd2;
        tg = ~tg;
        step(0, 4'd0, 1'b1, tg, 1'b1);
        period_wr = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            t = (k % 3 == 0);
            if (t) tg = ~tg;
            step(0, 4'(k % 3), t, tg, 1'b1);
        end

        phase = "enable";
        reset_a();
        tg = 1'b0;
        for (int i = 1; i <= 3; i++) step(0, 4'(i), 1'b0, tg, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 4'd3, 1'b0, tg, 1'b1);
        en = 1'b1;
        step(0, 4'd4, 1'b0, tg, 1'b1);
        tg = ~tg;
        step(0, 4'd0, 1'b1, tg, 1'b1);

        phase = "restart";
        for (int i = 1; i <= 4; i++) step(0, 4'(i), 1'b0, tg, 1'b1);
        start = 1'b1;
        step(0, 4'd0, 1'b0, tg, 1'b1);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) step(0, 4'(i), 1'b0, tg, 1'b1);
        tg = ~tg;
        step(0, 4'd0, 1'b1, tg, 1'b1);

        phase = "async_rst";
        for (int i = 1; i <= 4; i++) step(0, 4'(i), 1'b0, tg, 1'b1);
        tg = ~tg;
        step(0, 4'd0, 1'b1, tg, 1'b1);
        for (int i = 1; i <= 3; i++) step(0, 4'(i), 1'b0, tg, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("count",  count,          4'd0);
        chk("tick",   {3'b0, tick},   4'd0);
        chk("toggle", {3'b0, toggle}, 4'd0);
        chk("busy",   {3'b0, busy},   4'd1);
        rst = 1'b0;

        phase = "period_zero";
        tg = 1'b0;
        period_wr = 1'b1; period_in = 4'd3;
        step(0, 4'd1, 1'b0, tg, 1'b1);
        period_in = 4'd0;
        step(0, 4'd2, 1'b0, tg, 1'b1);
        period_wr = 1'b0;
        step(0, 4'd3, 1'b0, tg, 1'b1);
        step(0, 4'd4, 1'b0, tg, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tg = ~tg;
            step(0, 4'd0, 1'b1, tg, 1'b1);
        end

        phase = "one_shot";
        rst_b = 1'b1;
        #1;
        rst_b = 1'b0;
        chk("busy_b",  {3'b0, busy_b}, 4'd0);
        chk("count_b", count_b,        4'd0);
        tgb = 1'b0;
        step(1, 4'd0, 1'b0, tgb, 1'b0);
        for (int r = 0; r < 2; r++) begin
            start_b = 1'b1;
            step(1, 4'd0, 1'b0, tgb, 1'b1);
            start_b = 1'b0;
            for (int i = 1; i <= 4; i++) step(1, 4'(i), 1'b0, tgb, 1'b1);
            tgb = ~tgb;
            step(1, 4'd0, 1'b1, tgb, 1'b0);
            step(1, 4'd0, 1'b0, tgb, 1'b0);
            step(1, 4'd0, 1'b0, tgb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
